// File: rtl/seven_segment_scanner_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : seg7_pkg                                                  |
// | Description : Seven-segment code table, blank code, polarity helper.    |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] c_seg_off = 7'h7F;

  localparam logic [6:0] c_seg_code [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] code_al,
                                              input bit        active_low);
    return active_low ? code_al : ~code_al;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : seven_segment_scanner_if                                  |
// | Description : Data-in / display-pin bundle of the seven-segment scanner.|
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, load, lz_blank,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, lz_blank,
    output seg, dp, an, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : seven_segment_decoder                                     |
// | Description : Nibble to active-low segment code. Values A-F decode only |
// |               when SEVEN_SEGMENT_SCANNER_HEX_DECODE_EN is defined.      |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module seven_segment_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  always_comb begin
    code = c_seg_off;
`ifdef SEVEN_SEGMENT_SCANNER_HEX_DECODE_EN
    code = c_seg_code[nibble];
`else
    if (nibble < 4'd10) code = c_seg_code[nibble];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : seven_segment_scanner                                     |
// | Description : Time-multiplexed N-digit common-anode display driver with |
// |               tear-free frame buffering and leading-zero blanking.      |
// |               Hex glyphs enabled by SEVEN_SEGMENT_SCANNER_HEX_DECODE_EN.|
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  seven_segment_scanner_if.slave   bus
);

  localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_idx_w   = $clog2(NUM_DIGITS);

  logic [c_presc_w-1:0]    r_presc;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_idx_w-1:0]      w_idx_next;
  logic                    w_tick;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] r_disp_dig;
  logic [4*NUM_DIGITS-1:0] w_disp_dig_next;
  logic [4*NUM_DIGITS-1:0] r_pend_dig;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   w_disp_dp_next;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [NUM_DIGITS-1:0]   w_zero_above;
  logic                    w_run;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic [6:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_an_oh;

  assign w_tick = (r_presc == c_presc_w'(CLK_DIV - 1));
  assign w_wrap = w_tick && (r_idx == c_idx_w'(NUM_DIGITS - 1));

  // Outputs are registered from next-state values so the pins follow idx
  // and the freshly swapped frame in the cycle right after the tick.
  always_comb begin
    w_idx_next      = r_idx;
    w_disp_dig_next = r_disp_dig;
    w_disp_dp_next  = r_disp_dp;
    if (w_tick) w_idx_next = w_wrap ? '0 : r_idx + 1'b1;
    if (w_wrap) begin
      if (bus.load) begin
        w_disp_dig_next = bus.digits_in;
        w_disp_dp_next  = bus.dp_in;
      end else if (r_pend_valid) begin
        w_disp_dig_next = r_pend_dig;
        w_disp_dp_next  = r_pend_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_disp_dig   <= '0;
      r_disp_dp    <= '0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_idx      <= w_idx_next;
      r_disp_dig <= w_disp_dig_next;
      r_disp_dp  <= w_disp_dp_next;
      if (bus.load) begin
        r_pend_dig <= bus.digits_in;
        r_pend_dp  <= bus.dp_in;
      end
      if (w_wrap)        r_pend_valid <= 1'b0;
      else if (bus.load) r_pend_valid <= 1'b1;
    end
  end

  // w_zero_above[i]: digit i and every higher digit are zero.
  always_comb begin
    w_zero_above = '0;
    w_run        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run           = w_run && (w_disp_dig_next[4*i +: 4] == 4'd0);
      w_zero_above[i] = w_run;
    end
  end

  assign w_nib    = w_disp_dig_next[4*w_idx_next +: 4];
  assign w_dp_bit = w_disp_dp_next[w_idx_next];
  assign w_blank  = bus.lz_blank && (w_idx_next != '0) && w_zero_above[w_idx_next];
  assign w_an_oh  = NUM_DIGITS'(1) << w_idx_next;

  seven_segment_decoder u_dec (
    .nibble (w_nib),
    .code   (w_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg        <= seg_polarity(c_seg_off, SEG_ACTIVE_LOW != 0);
      bus.dp         <= (SEG_ACTIVE_LOW != 0);
      bus.an         <= (AN_ACTIVE_LOW != 0) ? '1 : '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_polarity(w_blank ? c_seg_off : w_code, SEG_ACTIVE_LOW != 0);
      bus.dp         <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_bit : w_dp_bit;
      bus.an         <= (AN_ACTIVE_LOW != 0) ? ~w_an_oh : w_an_oh;
      bus.frame_done <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment bank.
- Holds a frame of BCD/hex nibbles and scans one digit per refresh slot, driving shared segment lines and per-digit anode enables.
- Latches new values without tearing, and supports leading-zero blanking and per-digit decimal points.
- Sits between the application's numeric datapath and the board's display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- CLK_DIV, 50000: clk cycles per digit slot; must be ≥ 1.
- SEG_ACTIVE_LOW, 1: 1 means segment/dp lines are driven low to light; 0 means driven high to light.
- AN_ACTIVE_LOW, 1: 1 means the anode enable is asserted low; 0 means asserted high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- digits_in  in  4*NUM_DIGITS  nibble i at bits [4i+3:4i]; digit 0 is the rightmost/LSD.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  capture digits_in/dp_in into the pending buffer this cycle.
- lz_blank  in  1  enable leading-zero blanking; live, not latched.
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the scan wraps from NUM_DIGITS-1 to 0.

Behaviour:
- **Reset values:**
  - Prescaler = 0, idx = 0, display and pending buffers = 0, pending_valid = 0.
  - seg = all unlit (7'h7F when active-low), dp unlit, an = all deasserted, frame_done = 0.
  - Reset asserted mid-scan blanks the outputs immediately (asynchronously).
- **Prescaler:**
  - Counts 0..CLK_DIV-1; `tick` is asserted when count == CLK_DIV-1, and the count then returns to 0.
  - CLK_DIV = 1 gives tick every cycle.
- **Scan index:** on tick, idx increments; NUM_DIGITS-1 wraps to 0. frame_done = 1 on the cycle following the wrapping tick, otherwise 0.
- **Output timing:** all outputs are registered. In the cycle after a tick, an, seg and dp reflect the new idx. Only the an bit at position idx is asserted.
- **First scan:** after reset release, the first tick moves the scan to digit 1. Until then, outputs show digit 0 from the (zero) display buffer; this first output update occurs on the first clock after reset release.
- **Buffering:**
  - load writes pending and sets pending_valid; a later load overwrites pending.
  - On the wrapping tick, the display buffer takes the pending value if pending_valid is set, and pending_valid clears.
  - If load coincides with the wrapping tick, the display buffer takes digits_in/dp_in directly and pending_valid clears.
  - The display buffer never changes mid-frame.
- **Decode:**
  - Active-low codes for digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Values 10-15: see the optional feature.
  - Active-high operation uses the bitwise inverse.
- **Leading-zero blanking:** when lz_blank = 1, digit i (i ≥ 1) is blanked if it and every higher digit are 0. Digit 0 is never blanked. A blanked digit keeps its an asserted, with seg unlit and dp still driven from dp_in.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCANNER_HEX_DECODE_EN.
- **Defined:** active-low codes for 10-15 are A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- **Undefined:** values 10-15 decode to unlit, 7'h7F when active-low. In this mode they count as nonzero for leading-zero blanking.

Decomposition:
- **Package seg7_pkg:**
  - SEG_OFF constant.
  - Active-low code constants for 0-F.
  - An active-low-to-configured-polarity helper function.
- **Sub-module seven_segment_decoder:** combinational nibble-to-code decoder, honouring the hex macro. It is instantiated once on the muxed nibble.
- **Top level:** prescaler, scan counter, buffers, blanking logic and output registers.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, active-low):
1. Assert rst → seg = 7'h7F, dp = 1, an = 4'hF, frame_done = 0. Release rst and run 40 cycles → frame_done pulses every 16 cycles.
2. load 16'h1234, wait for frame_done → consecutive slots show an = 1110 / seg = 0011001, then 1101 / 0110000, then 1011 / 0100100, then 0111 / 1111001.
3. lz_blank = 1, load 16'h0050 → digits 3 and 2 give seg = 7'h7F, digit 1 gives 0010010, digit 0 gives 1000000. With lz_blank = 0, digits 3 and 2 give 1000000.
4. load 16'h1111 in slot 1 of a frame → the current frame still shows the old value; the new value appears from the slot after frame_done. A load coincident with the wrapping tick takes effect in that same next frame.
5. load nibble 4'hA → seg = 0001000 with the macro defined, 7'h7F without it. dp_in = 4'b0100 → dp = 0 only while an = 1011.
6. Assert rst asynchronously mid-slot → outputs go unlit the same cycle. After release, the scan restarts at digit 0 with a zero display buffer.
